// File: rtl/mux_n_registrado.sv
// Registered N:1 operand selector with a valid/ready stage and a 2-entry skid buffer.
// Out-of-range selector values pass zero data and raise a sticky error flag.
module mux_n_registrado #(
  parameter int LARGURA     = 32,
  parameter int ENTRADAS    = 4,
  parameter int SEL_LARGURA = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ENTRADAS*LARGURA-1:0]  entradas,
  input  logic [SEL_LARGURA-1:0]       seletor,
  input  logic                         valido_in,
  output logic                         pronto_out,
  output logic [LARGURA-1:0]           saida,
  output logic                         valido_out,
  input  logic                         pronto_in,
  output logic                         erro_sel
);

  // state | meaning
  // VAZIO | principal and skid empty
  // CHEIO | principal holds a beat, skid empty
  // SKID  | principal and skid both hold beats, upstream stalled
  // Encoding is {valido_p, valido_s} so the handshake outputs come straight from flops.
  typedef enum logic [1:0] {
    VAZIO = 2'b00,
    CHEIO = 2'b10,
    SKID  = 2'b11
  } estado_t;

  estado_t              estado_q, estado_d;
  logic [LARGURA-1:0]   dado_p_q, dado_p_d;
  logic [LARGURA-1:0]   dado_s_q, dado_s_d;
  logic                 erro_q, erro_d;
  logic [LARGURA-1:0]   sel_dado;
  logic                 sel_ok;
  logic                 aceita;
  logic                 consome;

  always_comb begin
    sel_dado = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < ENTRADAS; k++) begin
      if (seletor == SEL_LARGURA'(k)) begin
        sel_dado = entradas[k*LARGURA +: LARGURA];
        sel_ok   = 1'b1;
      end
    end
  end

  assign pronto_out = ~estado_q[0];
  assign valido_out = estado_q[1];
  assign saida      = dado_p_q;
  assign erro_sel   = erro_q;

  assign aceita  = valido_in & pronto_out;
  assign consome = valido_out & pronto_in;

  always_comb begin
    estado_d = estado_q;
    dado_p_d = dado_p_q;
    dado_s_d = dado_s_q;
    erro_d   = erro_q | (aceita & ~sel_ok);
    case (estado_q)
      VAZIO: begin
        if (aceita) begin
          dado_p_d = sel_dado;
          estado_d = CHEIO;
        end
      end
      CHEIO: begin
        if (consome && aceita) begin
          dado_p_d = sel_dado;
        end else if (consome) begin
          estado_d = VAZIO;
        end else if (aceita) begin
          dado_s_d = sel_dado;
          estado_d = SKID;
        end
      end
      SKID: begin
        if (consome) begin
          dado_p_d = dado_s_q;
          estado_d = CHEIO;
        end
      end
      default: estado_d = VAZIO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= VAZIO;
      dado_p_q <= '0;
      dado_s_q <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      dado_p_q <= dado_p_d;
      dado_s_q <= dado_s_d;
      erro_q   <= erro_d;
    end
  end

endmodule

// File: tb/tb_mux_n_registrado.sv
// Directed bench for mux_n_registrado: a 4-channel instance for the datapath
// and a 3-channel instance for out-of-range selection and reset flushing.
module tb_mux_n_registrado;

  logic         clock = 1'b0;
  logic         reset;

  logic [127:0] entradas4;
  logic [1:0]   seletor4;
  logic         valido_in4, pronto_in4;
  logic         pronto_out4, valido_out4, erro_sel4;
  logic [31:0]  saida4;

  logic [95:0]  entradas3;
  logic [1:0]   seletor3;
  logic         valido_in3, pronto_in3;
  logic         pronto_out3, valido_out3, erro_sel3;
  logic [31:0]  saida3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mux_n_registrado #(.LARGURA(32), .ENTRADAS(4), .SEL_LARGURA(2)) u_dut4 (
    .clock(clock), .reset(reset), .entradas(entradas4), .seletor(seletor4),
    .valido_in(valido_in4), .pronto_out(pronto_out4), .saida(saida4),
    .valido_out(valido_out4), .pronto_in(pronto_in4), .erro_sel(erro_sel4)
  );

  mux_n_registrado #(.LARGURA(32), .ENTRADAS(3), .SEL_LARGURA(2)) u_dut3 (
    .clock(clock), .reset(reset), .entradas(entradas3), .seletor(seletor3),
    .valido_in(valido_in3), .pronto_out(pronto_out3), .saida(saida3),
    .valido_out(valido_out3), .pronto_in(pronto_in3), .erro_sel(erro_sel3)
  );

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    entradas4  = '0;
    seletor4   = '0;
    valido_in4 = 1'b0;
    pronto_in4 = 1'b0;
    entradas3  = {32'h22222222, 32'h11111111, 32'h00000000};
    seletor3   = '0;
    valido_in3 = 1'b0;
    pronto_in3 = 1'b0;
    tick();
    tick();
    verifica("rst_valido_out", {31'b0, valido_out4}, 32'd0);
    verifica("rst_pronto_out", {31'b0, pronto_out4}, 32'd1);
    verifica("rst_saida", saida4, 32'h0);
    verifica("rst_erro_sel", {31'b0, erro_sel4}, 32'd0);
    reset = 1'b0;

    // single beat, selector 2
    pronto_in4 = 1'b1;
    entradas4  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    seletor4   = 2'd2;
    valido_in4 = 1'b1;
    tick();
    verifica("one_valido", {31'b0, valido_out4}, 32'd1);
    verifica("one_saida", saida4, 32'h22222222);
    valido_in4 = 1'b0;
    tick();
    verifica("one_drain", {31'b0, valido_out4}, 32'd0);

    // 8 back-to-back beats, distinct data per beat
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) entradas4[k*32 +: 32] = (i << 8) | k;
      seletor4   = 2'(i % 4);
      valido_in4 = 1'b1;
      tick();
      verifica($sformatf("strm_saida%0d", i), saida4, 32'((i << 8) | (i % 4)));
      verifica($sformatf("strm_valido%0d", i), {31'b0, valido_out4}, 32'd1);
      verifica($sformatf("strm_pronto%0d", i), {31'b0, pronto_out4}, 32'd1);
    end
    valido_in4 = 1'b0;
    tick();
    verifica("strm_drain", {31'b0, valido_out4}, 32'd0);

    // backpressure: A held, B in skid
    pronto_in4 = 1'b0;
    entradas4  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    seletor4   = 2'd1;
    valido_in4 = 1'b1;
    tick();
    verifica("bp_A_saida", saida4, 32'h11111111);
    verifica("bp_A_pronto", {31'b0, pronto_out4}, 32'd1);
    seletor4 = 2'd3;
    tick();
    verifica("bp_B_hold_saida", saida4, 32'h11111111);
    verifica("bp_B_pronto", {31'b0, pronto_out4}, 32'd0);
    valido_in4 = 1'b0;
    tick();
    verifica("bp_stall_saida", saida4, 32'h11111111);
    verifica("bp_stall_valido", {31'b0, valido_out4}, 32'd1);
    verifica("bp_stall_pronto", {31'b0, pronto_out4}, 32'd0);
    pronto_in4 = 1'b1;
    tick();
    verifica("bp_B_saida", saida4, 32'h33333333);
    verifica("bp_B_valido", {31'b0, valido_out4}, 32'd1);
    verifica("bp_pronto_back", {31'b0, pronto_out4}, 32'd1);
    tick();
    verifica("bp_drain", {31'b0, valido_out4}, 32'd0);

    // inputs change after acceptance while stalled
    pronto_in4 = 1'b0;
    entradas4  = {32'h33333333, 32'h22222222, 32'h11111111, 32'hAAAA0000};
    seletor4   = 2'd0;
    valido_in4 = 1'b1;
    tick();
    valido_in4 = 1'b0;
    entradas4  = {4{32'hFFFFFFFF}};
    seletor4   = 2'd2;
    tick();
    tick();
    verifica("stab_saida", saida4, 32'hAAAA0000);
    verifica("stab_valido", {31'b0, valido_out4}, 32'd1);
    pronto_in4 = 1'b1;
    tick();
    verifica("stab_drain", {31'b0, valido_out4}, 32'd0);

    // out-of-range selector on the 3-channel instance
    pronto_in3 = 1'b1;
    seletor3   = 2'd3;
    valido_in3 = 1'b1;
    tick();
    verifica("oor_saida", saida3, 32'h0);
    verifica("oor_valido", {31'b0, valido_out3}, 32'd1);
    verifica("oor_erro", {31'b0, erro_sel3}, 32'd1);
    seletor3 = 2'd1;
    tick();
    verifica("legal_saida", saida3, 32'h11111111);
    verifica("legal_erro_sticky", {31'b0, erro_sel3}, 32'd1);
    valido_in3 = 1'b0;
    tick();
    verifica("idle_erro_sticky", {31'b0, erro_sel3}, 32'd1);

    // fill both registers, then reset with accept and consume asserted
    pronto_in3 = 1'b0;
    seletor3   = 2'd2;
    valido_in3 = 1'b1;
    tick();
    tick();
    verifica("full_pronto", {31'b0, pronto_out3}, 32'd0);
    reset      = 1'b1;
    pronto_in3 = 1'b1;
    tick();
    verifica("flush_valido", {31'b0, valido_out3}, 32'd0);
    verifica("flush_pronto", {31'b0, pronto_out3}, 32'd1);
    verifica("flush_saida", saida3, 32'h0);
    verifica("flush_erro", {31'b0, erro_sel3}, 32'd0);
    reset      = 1'b0;
    valido_in3 = 1'b0;
    tick();
    verifica("flush_no_emit", {31'b0, valido_out3}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
